// File: rtl/sa_tile_sched_pkg.sv
// sa_tile_sched_pkg: shared definitions for the systolic-array tile scheduler.
//   - CNT_W_DEF / KK_W_DEF : default counter and pixel-word-count widths
//   - LVL_*                : loop levels, innermost first (oc_group, tile_col, tile_row)
//   - state_t              : scheduler FSM states
package sa_tile_sched_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned KK_W_DEF  = 32;

    // Loop order: oc_group innermost, then tile_col, then tile_row outermost.
    localparam int unsigned LVL_OCG = 0;
    localparam int unsigned LVL_COL = 1;
    localparam int unsigned LVL_ROW = 2;
    localparam int unsigned N_LVL   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FM,
        ST_ISSUE,
        ST_COMPUTE,
        ST_ADVANCE,
        ST_FIN
    } state_t;

endpackage

// File: rtl/sa_tile_loop_cnt.sv
// sa_tile_loop_cnt: three-level nested wrap counter, level 0 innermost.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : force all levels to 0
//   step       : advance the innermost level; carries ripple outward
//   lim        : per-level terminal value (count minus one)
//   cnt        : per-level current value
//   last       : per-level "at terminal value" flags
//   carry      : step while every level is at its terminal value (full wrap)
module sa_tile_loop_cnt
    import sa_tile_sched_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        step,
    input  logic [N_LVL-1:0][CNT_W-1:0] lim,
    output logic [N_LVL-1:0][CNT_W-1:0] cnt,
    output logic [N_LVL-1:0]            last,
    output logic                        carry
);

    logic [N_LVL-1:0] adv;

    // A level advances when stepped and every inner level is wrapping.
    always_comb begin
        last = '0;
        for (int unsigned i = 0; i < N_LVL; i++) begin
            last[i] = (cnt[i] == lim[i]);
        end
        adv    = '0;
        adv[0] = step;
        for (int unsigned i = 1; i < N_LVL; i++) begin
            adv[i] = adv[i-1] & last[i-1];
        end
        carry = step & (&last);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < N_LVL; i++) begin
                if (adv[i]) begin
                    cnt[i] <= last[i] ? '0 : cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sa_tile_sched.sv
// sa_tile_sched: walks a layer tile by tile (oc_group inner, col, row outer),
// handing each tile to the SA sequencer and ping-ponging feature-map banks.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   start                         : launch a layer (accepted only when idle)
//   cfg_rows_m1/cols_m1/ocg_m1    : loop extents minus one
//   cfg_nif_k_k                   : per-tile pixel-word count minus one
//   fm_ready                      : loader has a tile in bank fm_bank
//   sa_done                       : SA sequencer finished the current tile
//   re_fm_en                      : one-cycle tile-start pulse
//   nif_mult_k_mult_k             : latched cfg_nif_k_k
//   fm_bank, fm_release           : bank in use, one-cycle bank-free pulse
//   tile_row/tile_col/oc_group    : indices of the tile in flight
//   busy, done                    : not idle, one-cycle layer-end pulse
//   err_unexp_done                : sticky, sa_done seen outside COMPUTE
module sa_tile_sched
    import sa_tile_sched_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned KK_W  = KK_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_rows_m1,
    input  logic [CNT_W-1:0] cfg_cols_m1,
    input  logic [CNT_W-1:0] cfg_ocg_m1,
    input  logic [KK_W-1:0]  cfg_nif_k_k,
    input  logic             fm_ready,
    input  logic             sa_done,
    output logic             re_fm_en,
    output logic [KK_W-1:0]  nif_mult_k_mult_k,
    output logic             fm_bank,
    output logic             fm_release,
    output logic [CNT_W-1:0] tile_row,
    output logic [CNT_W-1:0] tile_col,
    output logic [CNT_W-1:0] oc_group,
    output logic             busy,
    output logic             done,
    output logic             err_unexp_done
);

    state_t                      state, state_next;
    logic [N_LVL-1:0][CNT_W-1:0] lim_q;
    logic [N_LVL-1:0][CNT_W-1:0] cnt;
    logic [N_LVL-1:0]            last;
    logic                        carry;
    logic                        step;
    logic                        start_acc;

    sa_tile_loop_cnt #(.CNT_W(CNT_W)) u_loop (
        .clk   (clk),
        .reset (reset),
        .clear (start_acc),
        .step  (step),
        .lim   (lim_q),
        .cnt   (cnt),
        .last  (last),
        .carry (carry)
    );

    assign oc_group = cnt[LVL_OCG];
    assign tile_col = cnt[LVL_COL];
    assign tile_row = cnt[LVL_ROW];

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            lim_q             <= '0;
            nif_mult_k_mult_k <= '0;
            fm_bank           <= 1'b0;
            err_unexp_done    <= 1'b0;
        end else begin
            state <= state_next;
            if (start_acc) begin
                lim_q[LVL_OCG]    <= cfg_ocg_m1;
                lim_q[LVL_COL]    <= cfg_cols_m1;
                lim_q[LVL_ROW]    <= cfg_rows_m1;
                nif_mult_k_mult_k <= cfg_nif_k_k;
                fm_bank           <= 1'b0;
            end else if (fm_release) begin
                fm_bank <= ~fm_bank;
            end
            // An accepted start clears the flag, but a coincident sa_done
            // still counts as unexpected.
            if (start_acc) begin
                err_unexp_done <= sa_done;
            end else if (sa_done && state != ST_COMPUTE) begin
                err_unexp_done <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        re_fm_en   = 1'b0;
        fm_release = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        step       = 1'b0;
        start_acc  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = ST_WAIT_FM;
                end
            end
            ST_WAIT_FM: begin
                if (fm_ready) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                re_fm_en   = 1'b1;
                state_next = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (sa_done) state_next = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                step       = 1'b1;
                fm_release = last[LVL_OCG];
                // Same bank serves every oc_group, so only a finished
                // group set needs a fresh feature-map tile.
                if (carry) begin
                    state_next = ST_FIN;
                end else if (last[LVL_OCG]) begin
                    state_next = ST_WAIT_FM;
                end else begin
                    state_next = ST_ISSUE;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sa_tile_sched.sv
module tb_sa_tile_sched;

    localparam int CW = 16;
    localparam int KW = 32;

    logic          clk = 1'b0;
    logic          reset, start, fm_ready, sa_done;
    logic [CW-1:0] cfg_rows_m1, cfg_cols_m1, cfg_ocg_m1;
    logic [KW-1:0] cfg_nif_k_k;
    logic          re_fm_en, fm_bank, fm_release, busy, done, err_unexp_done;
    logic [KW-1:0] nif_mult_k_mult_k;
    logic [CW-1:0] tile_row, tile_col, oc_group;

    int checks   = 0;
    int failures = 0;

    sa_tile_sched #(.CNT_W(CW), .KK_W(KW)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .cfg_rows_m1       (cfg_rows_m1),
        .cfg_cols_m1       (cfg_cols_m1),
        .cfg_ocg_m1        (cfg_ocg_m1),
        .cfg_nif_k_k       (cfg_nif_k_k),
        .fm_ready          (fm_ready),
        .sa_done           (sa_done),
        .re_fm_en          (re_fm_en),
        .nif_mult_k_mult_k (nif_mult_k_mult_k),
        .fm_bank           (fm_bank),
        .fm_release        (fm_release),
        .tile_row          (tile_row),
        .tile_col          (tile_col),
        .oc_group          (oc_group),
        .busy              (busy),
        .done              (done),
        .err_unexp_done    (err_unexp_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] row, col, ocg;
        logic          bank;
    } tile_t;

    typedef struct {
        logic [CW-1:0] r, c, o;
        logic [KW-1:0] kk;
        int            exp_issue, exp_rel;
        int            dmin, dmax;
        bit            rand_fm;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_pulses_flags"}, 64'({re_fm_en, fm_release, done, busy, err_unexp_done, fm_bank}), 64'd0);
        chk({tag, "_indices"}, 64'({tile_row, tile_col, oc_group}), 64'd0);
        chk({tag, "_nif"}, 64'(nif_mult_k_mult_k), 64'd0);
    endtask

    // Runs one layer against a model built from the nested loop order.
    // abort_tile != 0: reset while that tile (1-based) is in COMPUTE.
    task automatic run_layer(input logic [CW-1:0] r, c, o, input logic [KW-1:0] kk,
                             input int exp_issue, exp_rel, dmin, dmax,
                             input bit rand_fm, meddle, input int abort_tile);
        tile_t q[$];
        int fmidx = 0, n_issue = 0, n_rel = 0, n_done = 0;
        int cd = 0, last_d = 0, last_issue = -1, sd_per = 0, budget;
        bit fin = 0;
        for (int rr = 0; rr <= int'(r); rr++)
            for (int cc = 0; cc <= int'(c); cc++) begin
                for (int oo = 0; oo <= int'(o); oo++)
                    q.push_back('{CW'(rr), CW'(cc), CW'(oo), 1'(fmidx % 2)});
                fmidx++;
            end
        budget = q.size() * (dmax + 45) + 20;

        cfg_rows_m1 = r; cfg_cols_m1 = c; cfg_ocg_m1 = o; cfg_nif_k_k = kk;
        sa_done = 1'b0; fm_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_err_clear", 64'(err_unexp_done), 64'd0);
        if (meddle) begin
            cfg_rows_m1 = CW'($urandom); cfg_cols_m1 = CW'($urandom);
            cfg_ocg_m1  = CW'($urandom); cfg_nif_k_k = $urandom;
        end

        for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
            sa_done  = 1'b0;
            start    = 1'b0;
            fm_ready = rand_fm ? ($urandom_range(0, 3) == 0) : 1'b1;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    sa_done = 1'b1;
                    sd_per  = cyc - 1;
                end else if (meddle && $urandom_range(0, 1) == 1) begin
                    start = 1'b1;
                end
            end
            tick();
            if (re_fm_en) begin
                if (n_issue < q.size()) begin
                    chk("issue_row",  64'(tile_row), 64'(q[n_issue].row));
                    chk("issue_col",  64'(tile_col), 64'(q[n_issue].col));
                    chk("issue_ocg",  64'(oc_group), 64'(q[n_issue].ocg));
                    chk("issue_bank", 64'(fm_bank),  64'(q[n_issue].bank));
                    if (last_issue >= 0) begin
                        if (q[n_issue].ocg != 0 && last_d == 2)
                            chk("issue_min_spacing", 64'(cyc - last_issue), 64'd3);
                        else
                            chk("issue_spacing_ge3", 64'((cyc - last_issue) >= 3), 64'd1);
                    end
                end else begin
                    chk("extra_issue", 64'd1, 64'd0);
                end
                chk("nif_latched", 64'(nif_mult_k_mult_k), 64'(kk));
                last_issue = cyc;
                n_issue++;
                cd = $urandom_range(dmin, dmax);
                last_d = cd;
                if (abort_tile != 0 && n_issue == abort_tile) begin
                    start = 1'b0; sa_done = 1'b0;
                    tick();
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    chk_reset_outs("abort");
                    tick();
                    chk("abort_stays_idle", 64'({busy, re_fm_en, done, fm_release}), 64'd0);
                    return;
                end
            end
            if (fm_release) begin
                n_rel++;
                if (n_issue > 0) chk("release_on_last_ocg", 64'(q[n_issue-1].ocg), 64'(o));
            end
            if (done) begin
                chk("done_latency", 64'(cyc - sd_per), 64'd2);
                fin = 1;
                n_done++;
            end
        end
        start = 1'b0; sa_done = 1'b0;
        chk("layer_issues",   64'(n_issue), 64'(exp_issue));
        chk("layer_releases", 64'(n_rel),   64'(exp_rel));
        chk("layer_done",     64'(n_done),  64'd1);
        chk("layer_no_err",   64'(err_unexp_done), 64'd0);
        tick();
        chk("end_idle", 64'({busy, tile_row, tile_col, oc_group}), 64'd0);
        chk("end_nif_held", 64'(nif_mult_k_mult_k), 64'(kk));
    endtask

    vec_t vecs[4];

    initial begin
        int rr, cc, oo;
        vecs[0] = '{r: 0, c: 0, o: 0, kk: 32'h0000_0011, exp_issue: 1,  exp_rel: 1, dmin: 5, dmax: 5, rand_fm: 0};
        vecs[1] = '{r: 1, c: 2, o: 1, kk: 32'h0000_0123, exp_issue: 12, exp_rel: 6, dmin: 2, dmax: 2, rand_fm: 0};
        vecs[2] = '{r: 0, c: 3, o: 0, kk: 32'hDEAD_BEEF, exp_issue: 4,  exp_rel: 4, dmin: 2, dmax: 7, rand_fm: 1};
        vecs[3] = '{r: 2, c: 0, o: 2, kk: 32'h0000_0007, exp_issue: 9,  exp_rel: 3, dmin: 2, dmax: 4, rand_fm: 1};

        reset = 1'b1; start = 1'b0; fm_ready = 1'b0; sa_done = 1'b0;
        cfg_rows_m1 = '0; cfg_cols_m1 = '0; cfg_ocg_m1 = '0; cfg_nif_k_k = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk_reset_outs("por");

        foreach (vecs[i])
            run_layer(vecs[i].r, vecs[i].c, vecs[i].o, vecs[i].kk, vecs[i].exp_issue,
                      vecs[i].exp_rel, vecs[i].dmin, vecs[i].dmax, vecs[i].rand_fm, 0, 0);

        // Long fm_ready stall plus an unexpected sa_done while waiting.
        cfg_rows_m1 = '0; cfg_cols_m1 = '0; cfg_ocg_m1 = '0; cfg_nif_k_k = 32'd5;
        start = 1'b1; tick(); start = 1'b0;
        fm_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sa_done = (i == 10);
            tick();
            chk("stall_no_issue", 64'(re_fm_en), 64'd0);
            chk("stall_busy", 64'(busy), 64'd1);
            if (i == 10) chk("stall_err_set", 64'(err_unexp_done), 64'd1);
        end
        sa_done = 1'b0; fm_ready = 1'b1;
        tick();
        chk("stall_issue_next", 64'(re_fm_en), 64'd1);
        tick();
        sa_done = 1'b1; tick(); sa_done = 1'b0;
        chk("stall_release", 64'(fm_release), 64'd1);
        tick();
        chk("stall_done", 64'(done), 64'd1);
        tick();
        chk("stall_err_sticky", 64'({busy, err_unexp_done}), 64'b01);
        run_layer(0, 0, 0, 32'd9, 1, 1, 2, 3, 0, 0, 0);

        // start and sa_done together in IDLE.
        start = 1'b1; sa_done = 1'b1; tick(); start = 1'b0; sa_done = 1'b0;
        chk("idle_start_sadone", 64'({busy, err_unexp_done}), 64'b11);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_reset_outs("rst2");

        // Abort in COMPUTE of tile 3, then the same layer in full.
        run_layer(1, 2, 1, 32'hABCD, 12, 6, 2, 5, 0, 0, 3);
        run_layer(1, 2, 1, 32'hABCD, 12, 6, 2, 5, 1, 0, 0);

        // Stray starts and config churn mid-layer.
        run_layer(1, 1, 1, 32'h5555_AAAA, 8, 4, 2, 6, 1, 1, 0);

        for (int i = 0; i < 6; i++) begin
            rr = $urandom_range(0, 2); cc = $urandom_range(0, 2); oo = $urandom_range(0, 3);
            run_layer(CW'(rr), CW'(cc), CW'(oo), $urandom, (rr + 1) * (cc + 1) * (oo + 1),
                      (rr + 1) * (cc + 1), 2, 6, 1, i % 2 == 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sa_tile_sched.md
SA_TILE_SCHED -- requirements
Module: sa_tile_sched

Interface
REQ-001 Parameter CNT_W, default 16: width of tile/group counters and config counts.
REQ-002 Parameter KK_W, default 32: width of the per-tile pixel-word count.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse that launches a layer; honoured only in IDLE.
REQ-006 cfg_rows_m1, cfg_cols_m1, cfg_ocg_m1  in  CNT_W each  tile rows, tile columns and output-channel groups, minus one (0 means 1).
REQ-007 cfg_nif_k_k  in  KK_W  per-tile pixel-word count, minus one.
REQ-008 fm_ready  in  1  loader has a feature-map tile in bank fm_bank.
REQ-009 sa_done  in  1  one-cycle pulse from the SA sequencer when quantisation of the last output channel ends.
REQ-010 re_fm_en  out  1  one-cycle tile-start pulse to the SA sequencer.
REQ-011 nif_mult_k_mult_k  out  KK_W  latched cfg_nif_k_k, stable for the whole layer.
REQ-012 fm_bank  out  1  ping-pong bank being consumed.
REQ-013 fm_release  out  1  one-cycle pulse: bank fm_bank is free for reload.
REQ-014 tile_row, tile_col, oc_group  out  CNT_W each  indices of the tile in flight.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at layer end.
REQ-017 err_unexp_done  out  1  sticky flag: sa_done seen outside COMPUTE.

Function
REQ-018 FSM states: IDLE, WAIT_FM, ISSUE, COMPUTE, ADVANCE, FIN.
REQ-019 IDLE: start=1 latches all cfg_* and moves to WAIT_FM; indices are already 0.
REQ-020 WAIT_FM: fm_ready=1 moves to ISSUE; otherwise the FSM waits indefinitely.
REQ-021 ISSUE: re_fm_en=1 for exactly this cycle; the next state is COMPUTE.
REQ-022 COMPUTE: sa_done=1 moves to ADVANCE; only one tile is in flight at a time.
REQ-023 ADVANCE, single cycle, loop order oc_group innermost, then tile_col, then tile_row outermost:
- oc_group not last: oc_group+1, next state ISSUE, no fm wait, because the same bank is reused;
- oc_group last: oc_group=0, fm_release=1, fm_bank toggles, col/row advance with wrap to 0 and carry;
- all three last: next state FIN; otherwise WAIT_FM.
REQ-024 FIN: done=1 for one cycle, then IDLE; all indices are 0 on entry to IDLE.
REQ-025 Minimum spacing: 3 cycles between successive re_fm_en pulses (ISSUE->COMPUTE->ADVANCE->ISSUE).
REQ-026 start outside IDLE is ignored; cfg_* changes after latching have no effect.
REQ-027 sa_done in any state other than COMPUTE is ignored for sequencing and sets err_unexp_done; only reset or the next accepted start clears it.
REQ-028 sa_done and start in the same cycle in IDLE: start is accepted and err_unexp_done is set.
REQ-029 All-zero config (1x1x1): exactly one re_fm_en, one fm_release and one done pulse.

Reset
REQ-030 Reset outputs: state IDLE; re_fm_en, fm_release, done, busy, err_unexp_done, fm_bank = 0; all indices 0; nif_mult_k_mult_k = 0.
REQ-031 Reset mid-operation aborts the layer with no done or fm_release pulse; the SA sequencer is not reset by this block.

Structure
REQ-032 A shared package holds the state enum, CNT_W/KK_W defaults and the loop-order constant.
REQ-033 One sub-module, sa_tile_loop_cnt: a three-level wrap counter with step input, last flags and carry; everything else stays in the top level.

Verification
REQ-034 Config 1x1x1, fm_ready tied high, sa_done 5 cycles after re_fm_en -> one re_fm_en, one fm_release, done 2 cycles after sa_done.
REQ-035 Config rows_m1=1, cols_m1=2, ocg_m1=1 -> 12 re_fm_en; fm_release every 2nd sa_done; fm_bank sequence 0,1,0,1,0,1; indices in oc/col/row order.
REQ-036 fm_ready held low 20 cycles in WAIT_FM -> no re_fm_en during the wait; busy=1; issue occurs the cycle after fm_ready rises.
REQ-037 sa_done pulsed in WAIT_FM -> err_unexp_done=1, state unchanged; a later start clears the flag.
REQ-038 Reset asserted in COMPUTE of tile 3 -> next cycle all outputs at reset values; new start runs the full layer correctly.
REQ-039 start pulsed during COMPUTE, and cfg changed mid-layer -> no effect; nif_mult_k_mult_k keeps the value latched at start.
